counter_sequencer: RTL and testbench

- Control FSM for a WIDTH-bit up/down counter register bank built from async-reset D flip-flops.
- Latches a start configuration: load value, limit, direction and reload mode.
- Steps the count register each cycle, flags terminal count, supports pause and abort, and signals completion.
- Sits between a host/requester and the counter datapath; the single owner of the count enable and load.

---
 rtl/counter_sequencer_if.sv | 42 ++++
 rtl/counter_sequencer.sv | 138 +++++++++++++
 tb/tb_counter_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Host <-> counter sequencer bus: run configuration and control in, count and status out.
// Optional prescale field present only when COUNTER_SEQ_PRESCALE_EN is defined.
interface counter_sequencer_if #(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 8
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             up_down;
   logic             auto_reload;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] limit;
`ifdef COUNTER_SEQ_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale;
`endif
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             paused;
   logic             tc;
   logic             done;

`ifdef COUNTER_SEQ_PRESCALE_EN
   modport master (
      output start, stop, pause, up_down, auto_reload, load_val, limit, prescale,
      input  count, busy, paused, tc, done
   );
   modport slave (
      input  start, stop, pause, up_down, auto_reload, load_val, limit, prescale,
      output count, busy, paused, tc, done
   );
`else
   modport master (
      output start, stop, pause, up_down, auto_reload, load_val, limit,
      input  count, busy, paused, tc, done
   );
   modport slave (
      input  start, stop, pause, up_down, auto_reload, load_val, limit,
      output count, busy, paused, tc, done
   );
`endif
endinterface

// File: rtl/counter_sequencer.sv
// Control FSM and count register for a WIDTH-bit up/down counter.
// Latches a run configuration at start, steps once per action cycle, flags terminal
// count, supports pause/abort and optional auto-reload, pulses done on completion.
// Optional: COUNTER_SEQ_PRESCALE_EN adds a prescaler that gates the step action.
module counter_sequencer #(
   parameter int WIDTH      = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   counter_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] r_load;
   logic [WIDTH-1:0] r_limit;
   logic             r_up;
   logic             r_reload;
   logic             w_latch;
   logic             w_at_limit;
   logic             w_tick;

`ifdef COUNTER_SEQ_PRESCALE_EN
   logic [PRESCALE_W-1:0] r_pre;
   logic [PRESCALE_W-1:0] r_pre_lim;

   assign w_tick = (r_pre == r_pre_lim);

   // Prescaler: cleared at start, advances only on RUN cycles that are not aborted or paused.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre     <= '0;
         r_pre_lim <= '0;
      end else if (w_latch) begin
         r_pre     <= '0;
         r_pre_lim <= bus.prescale;
      end else if ((r_state == S_RUN) && !bus.stop && !bus.pause) begin
         r_pre <= w_tick ? '0 : r_pre + PRESCALE_W'(1);
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   assign w_at_limit = (r_count == r_limit);

   // Outputs decoded from registered state and count only.
   assign bus.count  = r_count;
   assign bus.busy   = (r_state == S_RUN) || (r_state == S_HOLD);
   assign bus.paused = (r_state == S_HOLD);
   assign bus.tc     = (r_state == S_RUN) && w_at_limit;
   assign bus.done   = (r_state == S_DONE);

   // State and count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Run configuration captured on the accepted start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load   <= '0;
         r_limit  <= '0;
         r_up     <= 1'b0;
         r_reload <= 1'b0;
      end else if (w_latch) begin
         r_load   <= bus.load_val;
         r_limit  <= bus.limit;
         r_up     <= bus.up_down;
         r_reload <= bus.auto_reload;
      end
   end

   // Next state and count: stop > pause > terminal > step while running.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               w_latch     = 1'b1;
               w_count_nxt = bus.load_val;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               w_state_nxt = S_IDLE;
            end else if (bus.pause) begin
               w_state_nxt = S_HOLD;
            end else if (w_tick) begin
               if (w_at_limit) begin
                  if (r_reload) begin
                     w_count_nxt = r_load;
                  end else begin
                     w_state_nxt = S_DONE;
                  end
               end else begin
                  w_count_nxt = r_up ? (r_count + ONE) : (r_count - ONE);
               end
            end
         end
         S_HOLD: begin
            if (bus.stop) begin
               w_state_nxt = S_IDLE;
            end else if (!bus.pause) begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed self-checking bench for counter_sequencer (WIDTH=4).
// Build with COUNTER_SEQ_PRESCALE_EN to also exercise the prescaler.
module tb_counter_sequencer;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   counter_sequencer_if #(.WIDTH(4), .PRESCALE_W(8)) bus ();

   counter_sequencer #(.WIDTH(4), .PRESCALE_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a configuration with start high for one edge; returns in the first RUN cycle.
   task automatic start_run(input int ld, input int lim, input bit up, input bit rl);
      bus.start       = 1'b1;
      bus.load_val    = 4'(ld);
      bus.limit       = 4'(lim);
      bus.up_down     = up;
      bus.auto_reload = rl;
      step();
      bus.start       = 1'b0;
   endtask

   int exp_cnt [8];
   int exp_tc  [8];

   initial begin
      errors = 0;
      checks = 0;
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.pause       = 1'b0;
      bus.up_down     = 1'b0;
      bus.auto_reload = 1'b0;
      bus.load_val    = '0;
      bus.limit       = '0;
`ifdef COUNTER_SEQ_PRESCALE_EN
      bus.prescale    = '0;
`endif
      #1;
      chk("rst_count", int'(bus.count), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_paused", int'(bus.paused), 0);
      chk("rst_tc", int'(bus.tc), 0);
      chk("rst_done", int'(bus.done), 0);
      step();
      step();
      reset = 1'b0;
      step();
      chk("idle_busy", int'(bus.busy), 0);

      // 1: up one-shot 3 -> 7
      exp_cnt[0:4] = '{3, 4, 5, 6, 7};
      exp_tc[0:4]  = '{0, 0, 0, 0, 1};
      start_run(3, 7, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t1_count%0d", i), int'(bus.count), exp_cnt[i]);
         chk($sformatf("t1_tc%0d", i), int'(bus.tc), exp_tc[i]);
         chk($sformatf("t1_busy%0d", i), int'(bus.busy), 1);
         chk($sformatf("t1_done%0d", i), int'(bus.done), 0);
         step();
      end
      chk("t1_done", int'(bus.done), 1);
      chk("t1_done_busy", int'(bus.busy), 0);
      chk("t1_done_count", int'(bus.count), 7);
      step();
      chk("t1_done_pulse", int'(bus.done), 0);
      chk("t1_idle_count", int'(bus.count), 7);
      chk("t1_idle_tc", int'(bus.tc), 0);

      // 2: down one-shot 1 -> 14 through wrap
      exp_cnt[0:3] = '{1, 0, 15, 14};
      exp_tc[0:3]  = '{0, 0, 0, 1};
      start_run(1, 14, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_count%0d", i), int'(bus.count), exp_cnt[i]);
         chk($sformatf("t2_tc%0d", i), int'(bus.tc), exp_tc[i]);
         step();
      end
      chk("t2_done", int'(bus.done), 1);
      step();

      // up wrap 14 -> 1
      exp_cnt[0:3] = '{14, 15, 0, 1};
      start_run(14, 1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_count%0d", i), int'(bus.count), exp_cnt[i]);
         step();
      end
      chk("wrap_done", int'(bus.done), 1);
      step();

      // load == limit: tc in first RUN cycle
      start_run(5, 5, 1'b1, 1'b0);
      chk("eq_count", int'(bus.count), 5);
      chk("eq_tc", int'(bus.tc), 1);
      step();
      chk("eq_done", int'(bus.done), 1);
      chk("eq_count_hold", int'(bus.count), 5);
      step();

      // 3: auto-reload 0..2, stop at count 1
      exp_cnt = '{0, 1, 2, 0, 1, 2, 0, 1};
      exp_tc  = '{0, 0, 1, 0, 0, 1, 0, 0};
      start_run(0, 2, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t3_count%0d", i), int'(bus.count), exp_cnt[i]);
         chk($sformatf("t3_tc%0d", i), int'(bus.tc), exp_tc[i]);
         chk($sformatf("t3_done%0d", i), int'(bus.done), 0);
         if (i < 7) step();
      end
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("t3_stop_busy", int'(bus.busy), 0);
      chk("t3_stop_count", int'(bus.count), 1);
      chk("t3_stop_done", int'(bus.done), 0);
      step();
      chk("t3_stop_done2", int'(bus.done), 0);
      chk("t3_idle_count", int'(bus.count), 1);

      // 4: pause three edges at count 5, resume, pause again, stop in HOLD
      start_run(5, 9, 1'b1, 1'b0);
      chk("t4_run_count", int'(bus.count), 5);
      bus.pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t4_hold_paused%0d", i), int'(bus.paused), 1);
         chk($sformatf("t4_hold_busy%0d", i), int'(bus.busy), 1);
         chk($sformatf("t4_hold_count%0d", i), int'(bus.count), 5);
      end
      bus.pause = 1'b0;
      step();
      chk("t4_resume_paused", int'(bus.paused), 0);
      chk("t4_resume_count", int'(bus.count), 5);
      step();
      chk("t4_step_count", int'(bus.count), 6);
      bus.pause = 1'b1;
      step();
      chk("t4_hold2_paused", int'(bus.paused), 1);
      chk("t4_hold2_tc", int'(bus.tc), 0);
      bus.pause = 1'b0;
      bus.stop  = 1'b1;
      step();
      bus.stop  = 1'b0;
      chk("t4_stop_busy", int'(bus.busy), 0);
      chk("t4_stop_paused", int'(bus.paused), 0);
      chk("t4_stop_count", int'(bus.count), 6);
      chk("t4_stop_done", int'(bus.done), 0);
      step();
      chk("t4_stop_done2", int'(bus.done), 0);

      // 5: asynchronous reset mid-run at count 9
      start_run(9, 3, 1'b1, 1'b0);
      chk("t5_pre_count", int'(bus.count), 9);
      #2 reset = 1'b1;
      #1;
      chk("t5_async_count", int'(bus.count), 0);
      chk("t5_async_busy", int'(bus.busy), 0);
      chk("t5_async_tc", int'(bus.tc), 0);
      #2 reset = 1'b0;
      step();
      chk("t5_idle_busy", int'(bus.busy), 0);
      chk("t5_idle_count", int'(bus.count), 0);

      // 6: start during RUN ignored; start+stop in IDLE ignored
      start_run(2, 12, 1'b1, 1'b0);
      chk("t6_count0", int'(bus.count), 2);
      bus.start    = 1'b1;
      bus.load_val = 4'd8;
      step();
      chk("t6_count1", int'(bus.count), 3);
      chk("t6_busy1", int'(bus.busy), 1);
      step();
      bus.start = 1'b0;
      chk("t6_count2", int'(bus.count), 4);
      bus.stop = 1'b1;
      step();
      chk("t6_stop_count", int'(bus.count), 4);
      bus.start    = 1'b1;
      bus.load_val = 4'd0;
      step();
      chk("t6_ss_busy", int'(bus.busy), 0);
      chk("t6_ss_count", int'(bus.count), 4);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      step();

`ifdef COUNTER_SEQ_PRESCALE_EN
      // prescale 2: one step every three RUN cycles
      bus.prescale = 8'd2;
      exp_cnt = '{0, 0, 0, 1, 1, 1, 2, 2};
      start_run(0, 9, 1'b1, 1'b0);
      bus.prescale = 8'd0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("pre_count%0d", i), int'(bus.count), exp_cnt[i]);
         step();
      end
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("pre_stop_busy", int'(bus.busy), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
